// File: rtl/booth_pkg.sv
// Shared types and constants for the radix-2 Booth multiplier.
package booth_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_M,
        S_LOAD_Q,
        S_EVAL,
        S_SHIFT,
        S_DONE
    } state_e;

    // Decode of {Q[0], q_1}
    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/booth_ctrl.sv
// Booth multiplier controller FSM. With BOOTH_FAST_EN defined, EVAL also
// shifts and decrements, so each iteration takes one cycle instead of two.
module booth_ctrl
    import booth_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    input  logic eqz_i,
    input  logic q0_i,
    input  logic q_1_i,
    output logic ld_m_o,
    output logic ld_q_o,
    output logic clr_a_o,
    output logic clr_f_o,
    output logic ld_cnt_o,
    output logic add_o,
    output logic sub_o,
    output logic shift_o,
    output logic dec_o,
    output logic done_o
);

    state_e     state_q, state_d;
    logic       ld_m_q, ld_q_q, shift_q, done_q;
    logic [1:0] op;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start_i) state_d = S_LOAD_M;
            S_LOAD_M: state_d = S_LOAD_Q;
            S_LOAD_Q: state_d = S_EVAL;
`ifdef BOOTH_FAST_EN
            S_EVAL:   if (eqz_i) state_d = S_DONE;
`else
            S_EVAL:   state_d = S_SHIFT;
            S_SHIFT:  state_d = eqz_i ? S_DONE : S_EVAL;
`endif
            S_DONE:   if (!start_i) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Strobes are registered as a decode of the next state, so they
    // line up with the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ld_m_q  <= 1'b0;
            ld_q_q  <= 1'b0;
            shift_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ld_m_q  <= (state_d == S_LOAD_M);
            ld_q_q  <= (state_d == S_LOAD_Q);
`ifdef BOOTH_FAST_EN
            shift_q <= (state_d == S_EVAL);
`else
            shift_q <= (state_d == S_SHIFT);
`endif
            done_q  <= (state_d == S_DONE);
        end
    end

    // add/sub depend on Q[0], which the previous shift just updated.
    assign op       = {q0_i, q_1_i};
    assign add_o    = (state_q == S_EVAL) && (op == BOOTH_ADD);
    assign sub_o    = (state_q == S_EVAL) && (op == BOOTH_SUB);

    assign ld_m_o   = ld_m_q;
    assign clr_a_o  = ld_m_q;
    assign clr_f_o  = ld_m_q;
    assign ld_cnt_o = ld_m_q;
    assign ld_q_o   = ld_q_q;
    assign shift_o  = shift_q;
    assign dec_o    = shift_q;
    assign done_o   = done_q;

endmodule

// File: rtl/booth_multiplier.sv
// Sequential signed radix-2 Booth multiplier: registers and add/sub ALU,
// controlled by booth_ctrl. Optional BOOTH_FAST_EN gives one-cycle iterations.
module booth_multiplier
    import booth_pkg::*;
#(
    parameter int N = 9
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   data_in,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int CW = cnt_w(N);

    logic [N-1:0]  m_q, m_d, q_q, q_d;
    logic [N:0]    a_q, a_d;
    logic          f_q, f_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          ld_m, ld_q, clr_a, clr_f, ld_cnt, add, sub, shift, dec, eqz;
    logic [N:0]    m_ext, alu, a_src;

    booth_ctrl u_ctrl (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start),
        .eqz_i    (eqz),
        .q0_i     (q_q[0]),
        .q_1_i    (f_q),
        .ld_m_o   (ld_m),
        .ld_q_o   (ld_q),
        .clr_a_o  (clr_a),
        .clr_f_o  (clr_f),
        .ld_cnt_o (ld_cnt),
        .add_o    (add),
        .sub_o    (sub),
        .shift_o  (shift),
        .dec_o    (dec),
        .done_o   (done)
    );

    // A is one bit wider than M so A - (-2^(N-1)) cannot overflow.
    assign m_ext = {m_q[N-1], m_q};
    assign alu   = sub ? (a_q - m_ext) : (a_q + m_ext);
    assign a_src = (add || sub) ? alu : a_q;
    assign eqz   = (cnt_q == CW'(1));

    always_comb begin
        m_d   = m_q;
        a_d   = a_q;
        q_d   = q_q;
        f_d   = f_q;
        cnt_d = cnt_q;
        if (ld_m)   m_d   = data_in;
        if (clr_a)  a_d   = '0;
        if (clr_f)  f_d   = 1'b0;
        if (ld_cnt) cnt_d = CW'(N);
        if (ld_q)   q_d   = data_in;
        // In the merged-iteration build the shift consumes the ALU result directly.
        if (shift) begin
            a_d = {a_src[N], a_src[N:1]};
            q_d = {a_src[0], q_q[N-1:1]};
            f_d = q_q[0];
        end else if (add || sub) begin
            a_d = alu;
        end
        if (dec)    cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_q   <= '0;
            a_q   <= '0;
            q_q   <= '0;
            f_q   <= 1'b0;
            cnt_q <= '0;
        end else begin
            m_q   <= m_d;
            a_q   <= a_d;
            q_q   <= q_d;
            f_q   <= f_d;
            cnt_q <= cnt_d;
        end
    end

    assign product = {a_q[N-1:0], q_q};

endmodule

// File: tb/tb_booth_multiplier.sv
// Directed-vector bench for booth_multiplier (N=9), hand-computed products.
module tb_booth_multiplier;

    localparam int N  = 9;
    localparam int W2 = 2 * N;
`ifdef BOOTH_FAST_EN
    localparam int EXP_LAT  = N + 2;
    localparam int ABORT_WT = 3;
`else
    localparam int EXP_LAT  = 2 * N + 2;
    localparam int ABORT_WT = 6;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [N-1:0]  data_in = '0;
    logic          done;
    logic [W2-1:0] product;

    int n_vec = 0;
    int n_bad = 0;

    booth_multiplier #(.N(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .data_in (data_in),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W2-1:0] got, input logic [W2-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drops start for one cycle, then issues E0/E1/E2; returns #1 after E2.
    task automatic launch(input logic [N-1:0] a, input logic [N-1:0] b, input logic hold);
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;        // E0
        start   = hold;
        data_in = a;
        @(posedge clk); #1;        // E1
        data_in = b;
        @(posedge clk); #1;        // E2
        data_in = '0;
    endtask

    task automatic finish_op(input string tag, input logic [W2-1:0] exp, input logic hold);
        int cyc = 2;
        while (!done && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, "_lat"}, W2'(cyc), W2'(EXP_LAT));
        chk({tag, "_prod"}, product, exp);
        if (hold) begin
            for (int i = 0; i < 10; i++) begin
                @(posedge clk); #1;
                chk({tag, "_hold_done"}, W2'(done), W2'(1));
                chk({tag, "_hold_prod"}, product, exp);
            end
        end
    endtask

    task automatic run_mul(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                           input logic [W2-1:0] exp, input logic hold);
        launch(a, b, hold);
        finish_op(tag, exp, hold);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_done", W2'(done), W2'(0));
        chk("rst_prod", product, '0);
        rst = 1'b0;

        run_mul("m185x255",  9'h147, 9'h0FF, 18'h347B9, 1'b0);
        run_mul("n256xn256", 9'h100, 9'h100, 18'h10000, 1'b0);
        run_mul("n256x255",  9'h100, 9'h0FF, 18'h30100, 1'b0);
        run_mul("255x255",   9'h0FF, 9'h0FF, 18'h0FE01, 1'b0);
        run_mul("0xn1",      9'h000, 9'h1FF, 18'h00000, 1'b0);
        run_mul("1xn256",    9'h001, 9'h100, 18'h3FF00, 1'b0);

        run_mul("hold",      9'h005, 9'h1FA, 18'h3FFE2, 1'b1);
        run_mul("3xn4",      9'h003, 9'h1FC, 18'h3FFF4, 1'b0);

        launch(9'h147, 9'h0FF, 1'b0);
        repeat (ABORT_WT) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_done", W2'(done), W2'(0));
        chk("abort_prod", product, '0);
        @(posedge clk); #1;
        chk("abort_idle", W2'(done), W2'(0));

        run_mul("7x9",       9'h007, 9'h009, 18'h0003F, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
